// File: rtl/xgriscv_defines_pkg.sv
// Shared LSU definitions: access-size encodings, FSM state encodings and
// small helpers for alignment checks and byte-lane enables.
package xgriscv_defines_pkg;

  // Access size as driven by the decoder (00 is treated as word).
  typedef enum logic [1:0] {
    SWHB_NONE = 2'b00,
    SWHB_WORD = 2'b01,
    SWHB_HALF = 2'b10,
    SWHB_BYTE = 2'b11
  } swhb_e;

  // LSU control states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10,
    ST_RESP = 2'b11
  } lsu_state_e;

  // High when the access cannot be served as a single aligned bus beat.
  function automatic logic is_misaligned(input logic [1:0] swhb, input logic [1:0] lo);
    logic r;
    case (swhb)
      SWHB_BYTE: r = 1'b0;
      SWHB_HALF: r = lo[0];
      default:   r = (lo != 2'b00);
    endcase
    return r;
  endfunction

  // Byte-lane enables for a 32-bit data bus.
  function automatic logic [3:0] lane_amp(input logic [1:0] swhb, input logic [1:0] lo);
    logic [3:0] r;
    case (swhb)
      SWHB_BYTE: r = 4'b0001 << lo;
      SWHB_HALF: r = lo[1] ? 4'b1100 : 4'b0011;
      default:   r = 4'b1111;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/xgriscv_lsu_loadext.sv
// Load-data lane selection and sign/zero extension (purely combinational).
module lsu_loadext
  import xgriscv_defines_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_rdata,
  input  logic [1:0]      i_lo,
  input  logic [1:0]      i_swhb,
  input  logic            i_lunsigned,
  output logic [XLEN-1:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Pick the addressed lane and extend it to the full data width.
  always_comb begin
    case (i_lo)
      2'b00:   w_byte = i_rdata[7:0];
      2'b01:   w_byte = i_rdata[15:8];
      2'b10:   w_byte = i_rdata[23:16];
      2'b11:   w_byte = i_rdata[31:24];
      default: w_byte = i_rdata[7:0];
    endcase
    if (i_lo[1]) begin
      w_half = i_rdata[31:16];
    end else begin
      w_half = i_rdata[15:0];
    end
    case (i_swhb)
      SWHB_BYTE: o_data = {{(XLEN-8){~i_lunsigned & w_byte[7]}}, w_byte};
      SWHB_HALF: o_data = {{(XLEN-16){~i_lunsigned & w_half[15]}}, w_half};
      default:   o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/xgriscv_lsu.sv
// Load/store unit: turns one MEM-stage access into a request/grant/rvalid
// data-memory transaction, stalling the pipeline until it completes.
module xgriscv_lsu
  import xgriscv_defines_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int MAX_WAIT = 255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  input  logic            req_we,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  input  logic [1:0]      req_swhb,
  input  logic            req_lunsigned,
  output logic            stall,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err,
  output logic            misalign,
  output logic            dm_req,
  output logic            dm_we,
  output logic [XLEN-1:0] dm_addr,
  output logic [XLEN-1:0] dm_wdata,
  output logic [3:0]      dm_amp,
  input  logic            dm_gnt,
  input  logic            dm_rvalid,
  input  logic [XLEN-1:0] dm_rdata
);

  // Wide enough to hold MAX_WAIT itself.
  localparam int CNT_W = $clog2(MAX_WAIT + 2);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  lsu_state_e      r_state;
  lsu_state_e      w_state_nxt;
  logic [XLEN-1:0] r_addr;
  logic [XLEN-1:0] r_wdata;
  logic [3:0]      r_amp;
  logic            r_we;
  logic [1:0]      r_swhb;
  logic            r_lunsigned;
  logic [CNT_W-1:0] r_cnt;
  logic [XLEN-1:0] r_rdata;
  logic            r_err;

  logic            w_misalign;
  logic            w_start;
  logic [CNT_W-1:0] w_cnt_inc;
  logic            w_timeout;
  logic [XLEN-1:0] w_wdata_repl;
  logic [XLEN-1:0] w_load_data;
  logic            w_enter_resp;
  logic [XLEN-1:0] w_rdata_nxt;
  logic            w_err_nxt;
  logic            w_in_req;

  assign w_misalign = is_misaligned(req_swhb, req_addr[1:0]);
  assign w_start    = (r_state == ST_IDLE) && req_valid && !w_misalign;
  assign w_cnt_inc  = r_cnt + CNT_ONE;
  // The counter reaches the budget at this edge.
  assign w_timeout  = (w_cnt_inc >= CNT_MAX);
  assign w_in_req   = (r_state == ST_REQ);

  lsu_loadext #(.XLEN(XLEN)) u_loadext (
    .i_rdata     (dm_rdata),
    .i_lo        (r_addr[1:0]),
    .i_swhb      (r_swhb),
    .i_lunsigned (r_lunsigned),
    .o_data      (w_load_data)
  );

  // Replicate store data across all lanes so the memory only needs dm_amp.
  always_comb begin
    case (req_swhb)
      SWHB_BYTE: w_wdata_repl = {(XLEN/8){req_wdata[7:0]}};
      SWHB_HALF: w_wdata_repl = {(XLEN/16){req_wdata[15:0]}};
      default:   w_wdata_repl = req_wdata;
    endcase
  end

  // Next-state logic and the values captured when entering RESP.
  always_comb begin
    w_state_nxt  = r_state;
    w_enter_resp = 1'b0;
    w_rdata_nxt  = {XLEN{1'b0}};
    w_err_nxt    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_state_nxt = ST_REQ;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (dm_gnt && r_we) begin
          w_state_nxt  = ST_RESP;
          w_enter_resp = 1'b1;
        end else if (w_timeout) begin
          w_state_nxt  = ST_RESP;
          w_enter_resp = 1'b1;
          w_err_nxt    = 1'b1;
        end else if (dm_gnt) begin
          w_state_nxt = ST_WAIT;
        end else begin
          w_state_nxt = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (dm_rvalid) begin
          w_state_nxt  = ST_RESP;
          w_enter_resp = 1'b1;
          w_rdata_nxt  = w_load_data;
        end else if (w_timeout) begin
          w_state_nxt  = ST_RESP;
          w_enter_resp = 1'b1;
          w_err_nxt    = 1'b1;
        end else begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_RESP: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Latch the access attributes when a new access is accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr      <= {XLEN{1'b0}};
      r_wdata     <= {XLEN{1'b0}};
      r_amp       <= 4'b0000;
      r_we        <= 1'b0;
      r_swhb      <= 2'b00;
      r_lunsigned <= 1'b0;
    end else if (w_start) begin
      r_addr      <= req_addr;
      r_wdata     <= w_wdata_repl;
      r_amp       <= lane_amp(req_swhb, req_addr[1:0]);
      r_we        <= req_we;
      r_swhb      <= req_swhb;
      r_lunsigned <= req_lunsigned;
    end
  end

  // Wait counter: cleared on entry to REQ, counts while the access is outstanding.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (w_start) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if ((r_state == ST_REQ) || (r_state == ST_WAIT)) begin
      r_cnt <= w_cnt_inc;
    end
  end

  // Response data holds until the next RESP; the error flag lives only in RESP.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdata <= {XLEN{1'b0}};
      r_err   <= 1'b0;
    end else if (w_enter_resp) begin
      r_rdata <= w_rdata_nxt;
      r_err   <= w_err_nxt;
    end else if (r_state == ST_RESP) begin
      r_err   <= 1'b0;
    end
  end

  assign stall      = w_start || (r_state == ST_REQ) || (r_state == ST_WAIT);
  assign misalign   = (r_state == ST_IDLE) && req_valid && w_misalign;
  assign resp_valid = (r_state == ST_RESP);
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;

  // Bus outputs are only driven while a request is on the bus.
  assign dm_req   = w_in_req;
  assign dm_we    = w_in_req && r_we;
  assign dm_addr  = w_in_req ? {r_addr[XLEN-1:2], 2'b00} : {XLEN{1'b0}};
  assign dm_wdata = w_in_req ? r_wdata : {XLEN{1'b0}};
  assign dm_amp   = w_in_req ? r_amp : 4'b0000;

endmodule

// File: tb/tb_xgriscv_lsu.sv
// Directed self-checking bench for xgriscv_lsu (MAX_WAIT = 4).
module tb_xgriscv_lsu;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_swhb;
  logic        req_lunsigned;
  logic        stall;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        misalign;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_amp;
  logic        dm_gnt;
  logic        dm_rvalid;
  logic [31:0] dm_rdata;

  int n_chk;
  int n_err;
  int n_resp;
  int n_stall;

  xgriscv_lsu #(.XLEN(32), .MAX_WAIT(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_we        (req_we),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .req_swhb      (req_swhb),
    .req_lunsigned (req_lunsigned),
    .stall         (stall),
    .resp_valid    (resp_valid),
    .resp_rdata    (resp_rdata),
    .resp_err      (resp_err),
    .misalign      (misalign),
    .dm_req        (dm_req),
    .dm_we         (dm_we),
    .dm_addr       (dm_addr),
    .dm_wdata      (dm_wdata),
    .dm_amp        (dm_amp),
    .dm_gnt        (dm_gnt),
    .dm_rvalid     (dm_rvalid),
    .dm_rdata      (dm_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count completion pulses mid-cycle.
  always begin
    @(posedge clk);
    #2;
    if (resp_valid) n_resp++;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got %h expected %h", tag, act, exp);
    end
  endtask

  // Store: gnt arrives in the gnt_dly-th REQ cycle.
  task automatic do_store(input logic [31:0] a, input logic [31:0] wd, input logic [1:0] sw,
                          input int gnt_dly, input logic [3:0] e_amp, input logic [31:0] e_wd);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = wd;
    req_swhb = sw; req_lunsigned = 1'b0;
    #1;
    chk("st_start_stall", stall, 1);
    chk("st_start_noreq", dm_req, 0);
    if (stall) n_stall++;
    for (int i = 0; i < gnt_dly; i++) begin
      @(negedge clk);
      dm_gnt = (i == gnt_dly - 1);
      #1;
      chk("st_dm_req", dm_req, 1);
      chk("st_dm_we", dm_we, 1);
      chk("st_dm_amp", dm_amp, e_amp);
      chk("st_dm_wdata", dm_wdata, e_wd);
      chk("st_dm_addr", dm_addr, {a[31:2], 2'b00});
      if (stall) n_stall++;
    end
    @(negedge clk);
    dm_gnt = 1'b0;
    #1;
    chk("st_resp_valid", resp_valid, 1);
    chk("st_resp_stall", stall, 0);
    chk("st_resp_rdata", resp_rdata, 0);
    chk("st_resp_err", resp_err, 0);
    chk("st_resp_noreq", dm_req, 0);
  endtask

  // Load: gnt in first REQ cycle, rvalid in first WAIT cycle.
  task automatic do_load(input logic [31:0] a, input logic [1:0] sw, input logic lu,
                         input logic [31:0] rd, input logic [3:0] e_amp, input logic [31:0] e_data);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = a; req_wdata = 32'h0;
    req_swhb = sw; req_lunsigned = lu;
    #1;
    chk("ld_start_stall", stall, 1);
    chk("ld_start_noreq", dm_req, 0);
    @(negedge clk);
    dm_gnt = 1'b1;
    #1;
    chk("ld_dm_req", dm_req, 1);
    chk("ld_dm_we", dm_we, 0);
    chk("ld_dm_amp", dm_amp, e_amp);
    chk("ld_dm_addr", dm_addr, {a[31:2], 2'b00});
    @(negedge clk);
    dm_gnt = 1'b0; dm_rvalid = 1'b1; dm_rdata = rd;
    #1;
    chk("ld_wait_stall", stall, 1);
    chk("ld_wait_noreq", dm_req, 0);
    @(negedge clk);
    dm_rvalid = 1'b0; dm_rdata = 32'h0;
    #1;
    chk("ld_resp_valid", resp_valid, 1);
    chk("ld_resp_rdata", resp_rdata, e_data);
    chk("ld_resp_err", resp_err, 0);
    chk("ld_resp_stall", stall, 0);
  endtask

  // Drop the request after completion; response data must hold.
  task automatic release_req(input logic [31:0] hold);
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    chk("rel_resp_valid", resp_valid, 0);
    chk("rel_stall", stall, 0);
    chk("rel_rdata_hold", resp_rdata, hold);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0; n_err = 0; n_resp = 0; n_stall = 0;
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0;
    req_wdata = 32'h0; req_swhb = 2'b00; req_lunsigned = 1'b0;
    dm_gnt = 1'b0; dm_rvalid = 1'b0; dm_rdata = 32'h0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_stall", stall, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_rdata", resp_rdata, 0);
    chk("rst_resp_err", resp_err, 0);
    chk("rst_misalign", misalign, 0);
    chk("rst_dm_req", dm_req, 0);
    chk("rst_dm_bus", {dm_we, dm_amp, dm_addr[26:0]}, 32'h0);
    chk("rst_dm_wdata", dm_wdata, 0);

    // Grant while idle is ignored.
    @(negedge clk);
    dm_gnt = 1'b1;
    @(negedge clk);
    dm_gnt = 1'b0;
    #1;
    chk("idle_gnt_ignored", {dm_req, resp_valid, stall}, 0);

    // Byte store with grant in the second REQ cycle, then back-to-back load.
    n_stall = 0;
    do_store(32'h8000_0003, 32'h0000_00AB, 2'b11, 2, 4'b1000, 32'hABAB_ABAB);
    chk("st_stall_cycles", n_stall, 3);
    do_load(32'h8000_0002, 2'b10, 1'b0, 32'h8001_1234, 4'b1100, 32'hFFFF_8001);
    release_req(32'hFFFF_8001);

    do_load(32'h8000_0002, 2'b10, 1'b1, 32'h8001_1234, 4'b1100, 32'h0000_8001);
    release_req(32'h0000_8001);

    do_store(32'h8000_0002, 32'h0000_BEEF, 2'b10, 1, 4'b1100, 32'hBEEF_BEEF);
    release_req(32'h0);

    do_load(32'h8000_0001, 2'b11, 1'b0, 32'h0000_F200, 4'b0010, 32'hFFFF_FFF2);
    release_req(32'hFFFF_FFF2);

    do_load(32'h8000_0004, 2'b00, 1'b0, 32'h1234_5678, 4'b1111, 32'h1234_5678);
    release_req(32'h1234_5678);

    // Reset while waiting for read data abandons the access.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h8000_000C; req_swhb = 2'b01; req_lunsigned = 1'b0;
    @(negedge clk);
    dm_gnt = 1'b1;
    @(negedge clk);
    dm_gnt = 1'b0; reset = 1'b1;
    #1;
    chk("rw_in_wait", {stall, dm_req}, 32'h2);
    @(negedge clk);
    reset = 1'b0; req_valid = 1'b0;
    #1;
    chk("rw_dm_req", dm_req, 0);
    chk("rw_stall", stall, 0);
    chk("rw_resp_valid", resp_valid, 0);
    chk("rw_rdata_clr", resp_rdata, 0);
    chk("rw_err_clr", resp_err, 0);
    chk("rw_amp", dm_amp, 0);
    @(negedge clk);
    dm_rvalid = 1'b1; dm_rdata = 32'h5555_AAAA;
    #1;
    chk("rw_late_rvalid", resp_valid, 0);
    @(negedge clk);
    dm_rvalid = 1'b0; dm_rdata = 32'h0;
    #1;
    chk("rw_late_rvalid2", {resp_valid, dm_req}, 0);

    // Misaligned accesses: flagged, no bus request, no stall.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h8000_0001; req_swhb = 2'b01;
    #1;
    chk("mis_word_flag", misalign, 1);
    chk("mis_word_stall", stall, 0);
    @(negedge clk);
    #1;
    chk("mis_word_noreq", dm_req, 0);
    chk("mis_word_hold", misalign, 1);
    @(negedge clk);
    req_we = 1'b1; req_addr = 32'h8000_0003; req_swhb = 2'b10;
    #1;
    chk("mis_half_flag", misalign, 1);
    @(negedge clk);
    req_we = 1'b0; req_addr = 32'h8000_0002; req_swhb = 2'b00;
    #1;
    chk("mis_w00_flag", misalign, 1);
    @(negedge clk);
    #1;
    chk("mis_w00_noreq", {dm_req, stall}, 0);
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    chk("mis_clear", misalign, 0);

    // No grant: timeout 4 cycles after REQ entry; rvalid in REQ is ignored.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h8000_0008; req_swhb = 2'b01;
    #1;
    chk("to_start_stall", stall, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      dm_rvalid = (i == 0);
      dm_rdata = (i == 0) ? 32'hDEAD_BEEF : 32'h0;
      #1;
      chk("to_dm_req", dm_req, 1);
      chk("to_no_resp", resp_valid, 0);
    end
    @(negedge clk);
    dm_rvalid = 1'b0;
    #1;
    chk("to_resp_valid", resp_valid, 1);
    chk("to_resp_err", resp_err, 1);
    chk("to_resp_rdata", resp_rdata, 0);
    chk("to_stall", stall, 0);
    release_req(32'h0);

    @(negedge clk);
    @(negedge clk);
    chk("resp_pulses", n_resp, 7);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/xgriscv_lsu.md
XGRISCV_LSU -- requirements
Module: xgriscv_lsu

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning data and address width.
REQ-002 SHALL have parameter MAX_WAIT, default 255, meaning the cycle budget before a memory timeout.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous and active-high.
REQ-005 SHALL have port req_valid, input, 1: the MEM stage holds a load/store, stable while stall=1.
REQ-006 SHALL have port req_we, input, 1: 1 = store, 0 = load.
REQ-007 SHALL have port req_addr, input, XLEN: byte address.
REQ-008 SHALL have port req_wdata, input, XLEN: store data, right-aligned.
REQ-009 SHALL have port req_swhb, input, 2: 01 = word, 10 = half, 11 = byte, 00 = treated as word.
REQ-010 SHALL have port req_lunsigned, input, 1: zero-extend loads.
REQ-011 SHALL have port stall, output, 1: freeze the pipeline.
REQ-012 SHALL have port resp_valid, output, 1: one-cycle completion.
REQ-013 SHALL have port resp_rdata, output, XLEN: extended load data.
REQ-014 SHALL have port resp_err, output, 1: timeout.
REQ-015 SHALL have port misalign, output, 1: misaligned access.
REQ-016 SHALL have ports dm_req (output, 1), dm_we (output, 1), dm_addr (output, XLEN, with [1:0] = 00), dm_wdata (output, XLEN) and dm_amp (output, 4, byte-lane enables).
REQ-017 SHALL have ports dm_gnt (input, 1), dm_rvalid (input, 1) and dm_rdata (input, XLEN).

Function
REQ-018 SHALL implement FSM states IDLE, REQ, WAIT and RESP.
REQ-019 IDLE: on req_valid with an aligned access, SHALL latch addr, we, swhb, lunsigned and lane-replicated wdata, then go to REQ; stall SHALL be 1 combinationally in that cycle.
REQ-020 Misaligned accesses (half with addr[0]=1; word with addr[1:0]≠00) in IDLE SHALL pulse misalign=1 combinationally, issue no memory access, hold stall=0 and stay in IDLE.
REQ-021 REQ: SHALL hold dm_req=1 with stable dm_we, dm_addr, dm_wdata and dm_amp until dm_gnt=1; on dm_gnt a store goes to RESP and a load goes to WAIT.
REQ-022 WAIT: on dm_rvalid=1, SHALL capture the extracted and extended data, then go to RESP.
REQ-023 RESP: SHALL drive resp_valid=1 and stall=0 for exactly one cycle, then go to IDLE; a req_valid seen in RESP SHALL NOT start a new access.
REQ-024 stall SHALL be 1 in REQ and WAIT.
REQ-025 dm_amp SHALL be: word 1111; half 0011 or 1100 by addr[1]; byte one-hot by addr[1:0].
REQ-026 Store data SHALL be replicated: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word unchanged.
REQ-027 Loads SHALL select the lane by latched addr[1:0], then sign-extend, or zero-extend when lunsigned=1.
REQ-028 A wait counter SHALL clear on entry to REQ and increment each cycle in REQ/WAIT; when it reaches MAX_WAIT, the FSM SHALL go to RESP with resp_err=1 and resp_rdata=0.
REQ-029 dm_rvalid arriving outside WAIT SHALL be ignored; dm_gnt arriving outside REQ SHALL be ignored.
REQ-030 resp_rdata SHALL be 0 for stores and SHALL hold its value until the next RESP.

Reset
REQ-031 When reset=1 at a clock edge, the block SHALL go to IDLE and clear the counter, latches, resp_rdata and resp_err.
REQ-032 Reset mid-transaction SHALL abandon the access, with dm_req=0 from the next cycle and no resp_valid.
REQ-033 After reset, all outputs SHALL be 0 while req_valid=0.

Structure
REQ-034 The swhb encodings and the FSM state encodings SHALL live in the shared xgriscv_defines header.
REQ-035 Lane extraction and extension SHALL be a combinational sub-module named lsu_loadext.

Verification
REQ-036 Store byte: addr 0x80000003, wdata 0x000000AB, gnt after 2 cycles -> dm_amp=1000, dm_wdata=0xABABABAB, dm_addr=0x80000000, stall high for 3 cycles, then one resp_valid.
REQ-037 Load half signed: addr 0x80000002, dm_rdata 0x8001_1234 -> resp_rdata=0xFFFF8001; with lunsigned=1 -> resp_rdata=0x00008001.
REQ-038 Misaligned word load at addr 0x80000001 -> misalign=1, dm_req never asserted, stall=0.
REQ-039 No gnt with MAX_WAIT=4 -> resp_valid with resp_err=1 and resp_rdata=0, exactly 4 cycles after REQ entry.
REQ-040 Reset asserted in WAIT -> next cycle in IDLE with dm_req=0; a later dm_rvalid produces no resp_valid.
REQ-041 Back-to-back store then load -> the second access starts only in the cycle after RESP; no duplicate access.
